// File: rtl/i2c_tca6416a_pkg.sv
// Shared definitions for the TCA6416A I2C transactions: addressing, register
// pointers, the per-slot encoding used by the read slot ROM, and debug state.
package i2c_tca6416a_pkg;

  localparam logic I2C_DIR_WRITE = 1'b0;
  localparam logic I2C_DIR_READ  = 1'b1;

  localparam logic [5:0] SLAVE_ADDR_PREFIX = 6'b010000;

  localparam logic [7:0] CMD_INPUT_0  = 8'h00;
  localparam logic [7:0] CMD_OUTPUT_0 = 8'h02;
  localparam logic [7:0] CMD_CONFIG_0 = 8'h06;

  localparam int XFER_LENGTH = 50;
  localparam int STOP_INDEX  = 48;
  localparam int INDEX_W     = 6;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_CHECK  = 2'd1,
    KIND_SHIFT0 = 2'd2,
    KIND_SHIFT1 = 2'd3
  } slot_kind_t;

  typedef struct packed {
    logic       sda;
    logic       skip;
    slot_kind_t kind;
  } slot_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } reader_state_t;

  typedef struct packed {
    reader_state_t        state;
    logic [INDEX_W-1:0]   index;
  } reader_dbg_t;

endpackage

// File: rtl/i2c_tca6416a_read_slot_rom.sv
// Slot table for the read transaction: maps slot index to the SDA level the
// master drives, whether SCL stays high after the slot, and what phase 2 samples.
module i2c_tca6416a_read_slot_rom
  import i2c_tca6416a_pkg::*;
(
  input  logic [INDEX_W-1:0] index,
  input  logic               unit,
  input  logic [7:0]         command,
  output slot_t              slot
);

  logic [6:0] addr;
  logic [2:0] addr_sel;
  logic [2:0] cmd_sel;

  assign addr     = {SLAVE_ADDR_PREFIX, unit};
  // Address appears twice: slots 1-7 and again after the repeated start, 21-27.
  assign addr_sel = (index < 6'd20) ? 3'(6'd7 - index) : 3'(6'd27 - index);
  assign cmd_sel  = 3'(6'd17 - index);

  always_comb begin
    slot = '{sda: 1'b1, skip: 1'b0, kind: KIND_NONE};
    case (index) inside
      6'd0:                 slot.sda  = 1'b0;
      [6'd1:6'd7]:          slot.sda  = addr[addr_sel];
      6'd8:                 slot.sda  = I2C_DIR_WRITE;
      6'd9, 6'd18, 6'd29:   slot.kind = KIND_CHECK;
      [6'd10:6'd17]:        slot.sda  = command[cmd_sel];
      6'd19:                slot.skip = 1'b1;
      6'd20:                slot.sda  = 1'b0;
      [6'd21:6'd27]:        slot.sda  = addr[addr_sel];
      6'd28:                slot.sda  = I2C_DIR_READ;
      [6'd30:6'd37]:        slot.kind = KIND_SHIFT0;
      6'd38:                slot.sda  = 1'b0;
      [6'd39:6'd46]:        slot.kind = KIND_SHIFT1;
      6'd47:                slot.sda  = 1'b1;
      6'd48: begin
        slot.sda  = 1'b0;
        slot.skip = 1'b1;
      end
      default:              slot.skip = 1'b1;
    endcase
  end

endmodule

// File: rtl/i2c_tca6416a_reader.sv
// TCA6416A register read over I2C: command write, repeated start, two data bytes.
// Build option I2C_TCA6416A_READER_NACK_ABORT_EN: a slave NACK jumps to the stop slot.
module i2c_tca6416a_reader
  import i2c_tca6416a_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        unit_i,
  input  logic [7:0]  command_i,
  input  logic        start_i,
  input  logic [1:0]  bit_phase_i,
  input  logic        bit_phase_inc_i,
  input  logic        sda_i,
  output logic        scl_o,
  output logic        sda_o,
  output logic        busy_o,
  output logic        stop_o,
  output logic        ack_error_o,
  output logic [7:0]  data_0_o,
  output logic [7:0]  data_1_o,
  output reader_dbg_t debug_o
);

  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(XFER_LENGTH - 1);
  localparam logic [INDEX_W-1:0] STOP_SLOT  = INDEX_W'(STOP_INDEX);

  reader_state_t      state;
  logic [INDEX_W-1:0] index;
  logic [7:0]         shift_0;
  logic [7:0]         shift_1;
  slot_t              slot;

  i2c_tca6416a_read_slot_rom u_slot_rom (
    .index   (index),
    .unit    (unit_i),
    .command (command_i),
    .slot    (slot)
  );

  assign debug_o.state = state;
  assign debug_o.index = index;

  // start_i is a level request taken only on an idle phase-3 strobe; busy_o is
  // high from that strobe until the strobe that pulses stop_o.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      index       <= '0;
      scl_o       <= 1'b1;
      sda_o       <= 1'b1;
      busy_o      <= 1'b0;
      stop_o      <= 1'b0;
      ack_error_o <= 1'b0;
      data_0_o    <= '0;
      data_1_o    <= '0;
      shift_0     <= '0;
      shift_1     <= '0;
    end else begin
      stop_o <= 1'b0;
      if (bit_phase_inc_i) begin
        case (state)
          ST_IDLE: begin
            scl_o <= 1'b1;
            sda_o <= 1'b1;
            index <= '0;
            if (bit_phase_i == 2'd3 && start_i) begin
              busy_o      <= 1'b1;
              ack_error_o <= 1'b0;
              state       <= ST_XFER;
            end
          end
          ST_XFER: begin
            case (bit_phase_i)
              2'd0: sda_o <= slot.sda;
              2'd1: scl_o <= 1'b1;
              2'd2: begin
                case (slot.kind)
                  KIND_CHECK:  if (sda_i) ack_error_o <= 1'b1;
                  KIND_SHIFT0: shift_0 <= {shift_0[6:0], sda_i};
                  KIND_SHIFT1: shift_1 <= {shift_1[6:0], sda_i};
                  default: ;
                endcase
              end
              default: begin
                scl_o <= slot.skip;
                if (index == LAST_INDEX) begin
                  stop_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
                  index  <= '0;
                  // A NACKed transfer leaves the last good readback in place.
                  if (!ack_error_o) begin
                    data_0_o <= shift_0;
                    data_1_o <= shift_1;
                  end
                end
`ifdef I2C_TCA6416A_READER_NACK_ABORT_EN
                else if (slot.kind == KIND_CHECK && ack_error_o) begin
                  scl_o <= 1'b0;
                  index <= STOP_SLOT;
                end
`endif
                else begin
                  index <= index + 1'b1;
                end
              end
            endcase
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
